// File: rtl/run_control_pkg.sv
// -----------------------------------------------------------------------------
// run_control_pkg
// Shared types for the JTAG run-control block: command and FSM state enums,
// the one-hot instruction codes this block reacts to, and the decode helper
// that maps an active instruction onto a run-control command.
// The `D_* instruction codes default to the values below unless the IR
// definition has already provided them.
// -----------------------------------------------------------------------------
`ifndef D_HALT
`define D_HALT   8'b0000_1000
`endif
`ifndef D_STEP
`define D_STEP   8'b0001_0000
`endif
`ifndef D_RESUME
`define D_RESUME 8'b0010_0000
`endif
`ifndef D_RESET
`define D_RESET  8'b0100_0000
`endif

package run_control_pkg;

  localparam int INST_COUNT = 8;

  localparam logic [INST_COUNT-1:0] INST_HALT   = `D_HALT;
  localparam logic [INST_COUNT-1:0] INST_STEP   = `D_STEP;
  localparam logic [INST_COUNT-1:0] INST_RESUME = `D_RESUME;
  localparam logic [INST_COUNT-1:0] INST_RESET  = `D_RESET;

  typedef enum logic [1:0] {
    CMD_HALT,
    CMD_STEP,
    CMD_RESUME,
    CMD_RESET
  } cmd_t;

  typedef enum logic [2:0] {
    RUN,
    HALTING,
    HALTED,
    STEPPING,
    RESETTING
  } state_t;

  typedef struct packed {
    logic valid;
    cmd_t cmd;
  } cmd_dec_t;

  function automatic cmd_dec_t decode_cmd(input logic [INST_COUNT-1:0] inst);
    cmd_dec_t d;
    d.valid = 1'b1;
    d.cmd   = CMD_HALT;
    if (inst == INST_HALT)        d.cmd = CMD_HALT;
    else if (inst == INST_STEP)   d.cmd = CMD_STEP;
    else if (inst == INST_RESUME) d.cmd = CMD_RESUME;
    else if (inst == INST_RESET)  d.cmd = CMD_RESET;
    else                          d.valid = 1'b0;
    return d;
  endfunction

endpackage

// File: rtl/sync_ff.sv
// -----------------------------------------------------------------------------
// sync_ff
// Multi-flop single-bit synchroniser with asynchronous active-low clear.
// Ports:
//   clk      in  destination clock
//   tl_reset in  async clear, active-low
//   d        in  bit from the source domain
//   q        out synchronised bit
// -----------------------------------------------------------------------------
module sync_ff #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic tl_reset,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain;

  always_ff @(posedge clk or negedge tl_reset) begin
    if (!tl_reset) chain <= '0;
    else           chain <= {chain[STAGES-2:0], d};
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/jtag_run_control.sv
// -----------------------------------------------------------------------------
// jtag_run_control
// Turns HALT/STEP/RESUME/RESET instructions seen at Update-IR into commands,
// carries them from tck to clk with a two-phase toggle req/ack handshake and
// runs the core run-control FSM. Status is synchronised back to tck for a DR.
//
// Ports:
//   tck          in   TAP clock
//   clk          in   core clock
//   tl_reset     in   async active-low reset for both domains
//   instructions in   one-hot active instruction (tck domain)
//   update_ir    in   Update-IR pulse (tck domain)
//   core_halted  in   core pipeline halted level (clk domain)
//   core_retired in   one-cycle retire pulse (clk domain)
//   halt_req     out  request core halt (clk domain)
//   core_reset   out  active-high core reset (clk domain)
//   status       out  {dropped, halted, busy} (tck domain)
//
// Build option: RUN_CONTROL_HALT_ON_RESET_EN keeps halt_req asserted through
// RESETTING and routes reset expiry to HALTING so the core leaves reset halted.
//
// state     | meaning
// RUN       | core running, no halt requested
// HALTING   | halt requested, waiting for core_halted
// HALTED    | core parked, accepting RESUME/STEP/HALT/RESET
// STEPPING  | halt released until one instruction retires
// RESETTING | core_reset held for RESET_CYCLES clk cycles
// -----------------------------------------------------------------------------
module jtag_run_control
  import run_control_pkg::*;
#(
  parameter int RESET_CYCLES = 16,
  parameter int SYNC_STAGES  = 2
) (
  input  logic                  tck,
  input  logic                  clk,
  input  logic                  tl_reset,
  input  logic [INST_COUNT-1:0] instructions,
  input  logic                  update_ir,
  input  logic                  core_halted,
  input  logic                  core_retired,
  output logic                  halt_req,
  output logic                  core_reset,
  output logic [2:0]            status
);

  localparam int CNT_W = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RESET_CYCLES - 1);

  // tck domain
  cmd_dec_t dec;
  cmd_t     cmd_q;
  logic     req_tgl;
  logic     ack_sync;
  logic     busy;
  logic     dropped;
  logic     halted_sync;

  // clk domain
  state_t           state, state_next;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic             ack_tgl;
  logic             ack_fire;
  logic             req_sync;
  logic             pending;
  logic             step_armed;
  logic             halted_flag;

  assign dec  = decode_cmd(instructions);
  assign busy = req_tgl ^ ack_sync;

  always_ff @(posedge tck or negedge tl_reset) begin
    if (!tl_reset) begin
      req_tgl <= 1'b0;
      cmd_q   <= CMD_HALT;
      dropped <= 1'b0;
    end else if (update_ir && dec.valid) begin
      if (!busy) begin
        cmd_q   <= dec.cmd;
        req_tgl <= ~req_tgl;
      end else begin
        dropped <= 1'b1;
      end
    end
  end

  sync_ff #(.STAGES(SYNC_STAGES)) u_sync_ack (
    .clk      (tck),
    .tl_reset (tl_reset),
    .d        (ack_tgl),
    .q        (ack_sync)
  );

  sync_ff #(.STAGES(SYNC_STAGES)) u_sync_halted (
    .clk      (tck),
    .tl_reset (tl_reset),
    .d        (halted_flag),
    .q        (halted_sync)
  );

  assign status = {dropped, halted_sync, busy};

  sync_ff #(.STAGES(SYNC_STAGES)) u_sync_req (
    .clk      (clk),
    .tl_reset (tl_reset),
    .d        (req_tgl),
    .q        (req_sync)
  );

  // cmd_q is held stable by the tck side while a request is outstanding,
  // so it is safe to read directly whenever pending is set.
  assign pending = req_sync ^ ack_tgl;

  always_ff @(posedge clk or negedge tl_reset) begin
    if (!tl_reset) begin
      state       <= RUN;
      cnt         <= '0;
      ack_tgl     <= 1'b0;
      step_armed  <= 1'b0;
      halted_flag <= 1'b0;
    end else begin
      state       <= state_next;
      cnt         <= cnt_next;
      ack_tgl     <= ack_tgl ^ ack_fire;
      // Arms one cycle after entering STEPPING so a retire pulse that
      // coincides with the entry cycle is not counted.
      step_armed  <= (state == STEPPING) && (state_next == STEPPING);
      // Registered copy of the state decode so the CDC source is glitch-free.
      halted_flag <= (state_next == HALTED);
    end
  end

  always_comb begin
    state_next = state;
    cnt_next   = '0;
    ack_fire   = 1'b0;
    halt_req   = 1'b0;
    core_reset = 1'b0;
    case (state)
      RUN: begin
        if (pending) begin
          case (cmd_q)
            CMD_HALT:  state_next = HALTING;
            CMD_RESET: state_next = RESETTING;
            default:   ack_fire   = 1'b1;
          endcase
        end
      end
      HALTING: begin
        halt_req = 1'b1;
        // Every path into HALTING leaves its command outstanding; it
        // completes here.
        if (core_halted) begin
          state_next = HALTED;
          ack_fire   = pending;
        end
      end
      HALTED: begin
        halt_req = 1'b1;
        if (pending) begin
          case (cmd_q)
            CMD_RESUME: begin
              state_next = RUN;
              ack_fire   = 1'b1;
            end
            CMD_STEP:  state_next = STEPPING;
            CMD_RESET: state_next = RESETTING;
            default:   ack_fire   = 1'b1;
          endcase
        end
      end
      STEPPING: begin
        if (step_armed && core_retired) state_next = HALTING;
      end
      RESETTING: begin
        core_reset = 1'b1;
`ifdef RUN_CONTROL_HALT_ON_RESET_EN
        halt_req = 1'b1;
`endif
        if (cnt == CNT_LAST) begin
`ifdef RUN_CONTROL_HALT_ON_RESET_EN
          state_next = HALTING;
`else
          state_next = RUN;
          ack_fire   = 1'b1;
`endif
        end else begin
          cnt_next = cnt + 1'b1;
        end
      end
      default: state_next = RUN;
    endcase
  end

endmodule

// File: tb/tb_jtag_run_control.sv
module tb_jtag_run_control;
  import run_control_pkg::*;

  localparam int RESET_CYCLES = 16;
  localparam int SYNC_STAGES  = 2;
`ifdef RUN_CONTROL_HALT_ON_RESET_EN
  localparam logic HOR = 1'b1;
`else
  localparam logic HOR = 1'b0;
`endif

  logic                  tck = 1'b0;
  logic                  clk = 1'b0;
  logic                  tl_reset = 1'b0;
  logic [INST_COUNT-1:0] instructions = '0;
  logic                  update_ir = 1'b0;
  logic                  core_halted = 1'b0;
  logic                  core_retired = 1'b0;
  logic                  halt_req;
  logic                  core_reset;
  logic [2:0]            status;

  int n_checks = 0;
  int n_pass   = 0;

  // Abstract model: what the status DR should read once the bench is idle.
  logic exp_halted  = 1'b0;
  logic exp_dropped = 1'b0;

  always #15 tck = ~tck;
  always #5  clk = ~clk;

  jtag_run_control #(
    .RESET_CYCLES (RESET_CYCLES),
    .SYNC_STAGES  (SYNC_STAGES)
  ) dut (
    .tck          (tck),
    .clk          (clk),
    .tl_reset     (tl_reset),
    .instructions (instructions),
    .update_ir    (update_ir),
    .core_halted  (core_halted),
    .core_retired (core_retired),
    .halt_req     (halt_req),
    .core_reset   (core_reset),
    .status       (status)
  );

  initial begin
    #2000000;
    $fatal(1, "FAIL watchdog: simulation time limit reached");
  end

  function automatic logic [2:0] exp_status();
    return {exp_dropped, exp_halted, 1'b0};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic issue(input logic [INST_COUNT-1:0] code);
    @(negedge tck);
    instructions = code;
    update_ir    = 1'b1;
    @(negedge tck);
    update_ir    = 1'b0;
    instructions = '0;
  endtask

  task automatic wait_halt_req(input logic val, input int max, input string tag);
    logic found = 1'b0;
    for (int i = 0; i < max; i++) begin
      @(negedge clk);
      if (halt_req === val) begin
        found = 1'b1;
        break;
      end
    end
    check(tag, found, 1);
  endtask

  task automatic wait_idle(input int max, input string tag);
    logic found = 1'b0;
    for (int i = 0; i < max; i++) begin
      @(negedge tck);
      if (status[0] === 1'b0) begin
        found = 1'b1;
        break;
      end
    end
    check(tag, found, 1);
  endtask

  task automatic wait_core_reset(input int max, input string tag);
    logic found = 1'b0;
    for (int i = 0; i < max; i++) begin
      @(negedge clk);
      if (core_reset === 1'b1) begin
        found = 1'b1;
        break;
      end
    end
    check(tag, found, 1);
  endtask

  initial begin
    logic [INST_COUNT-1:0] others [4];
    int dly;
    int cnt;
    int hr_bad;
    logic hr_exp;

    others[0] = 8'b0000_0001;
    others[1] = 8'b0000_0010;
    others[2] = 8'b0000_0100;
    others[3] = 8'b1000_0000;

    // 1. reset
    repeat (3) @(negedge tck);
    #1;
    check("rst_halt_req", halt_req, 0);
    check("rst_core_reset", core_reset, 0);
    check("rst_status", status, 3'b000);
    @(negedge tck);
    tl_reset = 1'b1;
    repeat (4) @(negedge tck);
    check("post_rst_status", status, exp_status());
    check("post_rst_halt_req", halt_req, 0);

    // unrelated instructions and run-control codes without update_ir do nothing
    issue(others[$urandom_range(0, 3)]);
    @(negedge tck);
    instructions = INST_HALT;
    repeat (6) @(negedge tck);
    instructions = '0;
    check("other_inst_status", status, exp_status());
    check("other_inst_halt_req", halt_req, 0);

    // 2. HALT, core acknowledges a random number of cycles later
    issue(INST_HALT);
    wait_halt_req(1'b1, 20, "halt_req_rise");
    dly = $urandom_range(3, 8);
    hr_bad = 0;
    repeat (dly) begin
      @(negedge clk);
      if (halt_req !== 1'b1) hr_bad++;
    end
    check("halting_hold", hr_bad, 0);
    @(negedge tck);
    check("halting_busy", status[0], 1);
    @(negedge clk);
    core_halted = 1'b1;
    exp_halted  = 1'b1;
    wait_idle(SYNC_STAGES + 6, "halt_idle");
    check("halt_status", status, exp_status());
    check("halt_halt_req", halt_req, 1);

    // 3. single steps from HALTED
    for (int it = 0; it < 2; it++) begin
      issue(INST_STEP);
      wait_halt_req(1'b0, 20, "step_release");
      core_halted = 1'b0;
      if (it == 0) begin
        core_retired = 1'b1;
        @(negedge clk);
        core_retired = 1'b0;
        check("step_entry_retire_ignored", halt_req, 0);
      end
      dly = $urandom_range(1, 6);
      hr_bad = 0;
      repeat (dly) begin
        @(negedge clk);
        if (halt_req !== 1'b0) hr_bad++;
      end
      check("step_low_until_retire", hr_bad, 0);
      core_retired = 1'b1;
      @(negedge clk);
      core_retired = 1'b0;
      check("step_rehalt", halt_req, 1);
      @(negedge tck);
      check("step_busy", status[0], 1);
      repeat ($urandom_range(0, 4)) @(negedge clk);
      core_halted = 1'b1;
      wait_idle(SYNC_STAGES + 6, "step_idle");
      check("step_status", status, exp_status());
    end

    // 4. RESET pulse width and exit state
    issue(INST_RESET);
    hr_exp = HOR;
    wait_core_reset(20, "reset_rise");
    core_halted = 1'b0;
    cnt = 1;
    hr_bad = (halt_req !== hr_exp) ? 1 : 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (core_reset !== 1'b1) break;
      cnt++;
      if (halt_req !== hr_exp) hr_bad++;
    end
    check("reset_width", cnt, RESET_CYCLES);
    check("reset_halt_req", hr_bad, 0);
    check("reset_exit_halt_req", halt_req, hr_exp);
    core_halted = 1'b1;
    exp_halted  = HOR;
    wait_idle(SYNC_STAGES + 8, "reset_idle");
    check("reset_status", status, exp_status());

    // 5. request while busy is dropped and sticky
    issue(INST_RESUME);
    issue(INST_HALT);
    exp_dropped = 1'b1;
    exp_halted  = 1'b0;
    check("dropped_set", status[2], 1);
    wait_idle(SYNC_STAGES + 8, "resume_idle");
    core_halted = 1'b0;
    check("resume_status", status, exp_status());
    @(negedge clk);
    check("resume_halt_req", halt_req, 0);
    // core_halted already high when HALTING is entered
    core_halted = 1'b1;
    issue(INST_HALT);
    exp_halted = 1'b1;
    wait_idle(SYNC_STAGES + 10, "fast_halt_idle");
    check("dropped_sticky_status", status, exp_status());
    @(negedge clk);
    check("fast_halt_halt_req", halt_req, 1);

    // 6. tl_reset in the middle of RESETTING
    issue(INST_RESET);
    wait_core_reset(20, "reset2_rise");
    repeat (7) @(negedge clk);
    tl_reset    = 1'b0;
    exp_dropped = 1'b0;
    exp_halted  = 1'b0;
    #1;
    check("midrst_core_reset", core_reset, 0);
    check("midrst_halt_req", halt_req, 0);
    check("midrst_status", status, exp_status());
    core_halted = 1'b0;
    repeat (3) @(negedge tck);
    tl_reset = 1'b1;
    repeat (4) @(negedge tck);
    check("midrst_release_status", status, exp_status());
    check("midrst_release_core_reset", core_reset, 0);
    check("midrst_release_halt_req", halt_req, 0);
    issue(INST_HALT);
    wait_halt_req(1'b1, 20, "post_midrst_halt_rise");
    repeat ($urandom_range(1, 5)) @(negedge clk);
    core_halted = 1'b1;
    exp_halted  = 1'b1;
    wait_idle(SYNC_STAGES + 6, "post_midrst_idle");
    check("post_midrst_status", status, exp_status());

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
